// File: rtl/at_decoder.sv
// at_decoder: decode-stage classifier for the 5-stage MIPS pipeline.
// Produces the register-usage triple (RS/RT/WR), a 5-bit instruction
// class and a multiply/divide flag for the hazard unit. Decode is purely
// combinational; a one-bit ready flag gates the outputs to nop until the
// first clock edge after reset is released.
module at_decoder (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  output logic [4:0]  RS,
  output logic [4:0]  RT,
  output logic [4:0]  WR,
  output logic [4:0]  Instype,
  output logic        md_stall
);

  typedef enum logic [4:0] {
    C_NOP     = 5'd0,
    C_CAL_R   = 5'd1,
    C_CAL_I   = 5'd2,
    C_LOAD    = 5'd3,
    C_STORE   = 5'd4,
    C_BRANCH  = 5'd5,
    C_JR      = 5'd6,
    C_JAL     = 5'd7,
    C_JALR    = 5'd8,
    C_LWL     = 5'd9,
    C_LWPL    = 5'd10,
    C_BGEZAL  = 5'd11,
    C_BGEZALR = 5'd12
  } iclass_t;

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [5:0] funct;

  assign op    = Instr[31:26];
  assign rs    = Instr[25:21];
  assign rt    = Instr[20:16];
  assign rd    = Instr[15:11];
  assign funct = Instr[5:0];

  logic    ready;
  iclass_t cls;
  logic [4:0] dec_rs;
  logic [4:0] dec_rt;
  logic [4:0] dec_wr;
  logic       dec_md;

  // Ready flag: cleared asynchronously by reset, set on first edge after.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) ready <= 1'b0;
    else        ready <= 1'b1;
  end

  // Instruction decode; any unlisted encoding falls through as nop.
  always_comb begin
    cls    = C_NOP;
    dec_rs = '0;
    dec_rt = '0;
    dec_wr = '0;
    dec_md = 1'b0;
    unique case (op)
      6'h00: begin
        unique case (funct)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07: begin
            cls = C_CAL_R; dec_rs = rs; dec_rt = rt; dec_wr = rd;
          end
          // An all-zero word is the canonical nop, not sll $0,$0,0.
          6'h00, 6'h02, 6'h03: begin
            if (Instr != '0) begin
              cls = C_CAL_R; dec_rt = rt; dec_wr = rd;
            end
          end
          6'h08: begin cls = C_JR; dec_rs = rs; end
          6'h09: begin cls = C_JALR; dec_rs = rs; dec_wr = rd; end
          6'h05: begin
            cls = C_BGEZALR; dec_rs = rs; dec_rt = rt; dec_wr = 5'd31;
          end
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            cls = C_CAL_R; dec_rs = rs; dec_rt = rt; dec_md = 1'b1;
          end
          6'h11, 6'h13: begin cls = C_CAL_R; dec_rs = rs; dec_md = 1'b1; end
          6'h10, 6'h12: begin cls = C_CAL_R; dec_wr = rd; dec_md = 1'b1; end
          default: ;
        endcase
      end
      6'h01: begin
        unique case (rt)
          5'h00, 5'h01: begin cls = C_BRANCH; dec_rs = rs; end
          5'h11:        begin cls = C_BGEZAL; dec_rs = rs; dec_wr = 5'd31; end
          default: ;
        endcase
      end
      6'h04, 6'h05: begin cls = C_BRANCH; dec_rs = rs; dec_rt = rt; end
      6'h06, 6'h07: begin cls = C_BRANCH; dec_rs = rs; end
      6'h03:        begin cls = C_JAL; dec_wr = 5'd31; end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
        cls = C_CAL_I; dec_rs = rs; dec_wr = rt;
      end
      6'h0F: begin cls = C_CAL_I; dec_wr = rt; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        cls = C_LOAD; dec_rs = rs; dec_wr = rt;
      end
      6'h28, 6'h29, 6'h2B: begin cls = C_STORE; dec_rs = rs; dec_rt = rt; end
      6'h22: begin cls = C_LWL; dec_rs = rs; dec_rt = rt; dec_wr = rt; end
      6'h33: begin cls = C_LWPL; dec_rs = rs; dec_wr = rt; end
      default: ;
    endcase
  end

  // Output gating: force nop while not ready (includes reset asserted now).
  always_comb begin
    Instype  = '0;
    RS       = '0;
    RT       = '0;
    WR       = '0;
    md_stall = 1'b0;
    if (ready && Reset) begin
      Instype  = cls;
      RS       = dec_rs;
      RT       = dec_rt;
      WR       = dec_wr;
      md_stall = dec_md;
    end
  end

endmodule

// File: tb/tb_at_decoder.sv
// Directed testbench for at_decoder with hand-computed expected outputs.
module tb_at_decoder;

  logic        Clk;
  logic        Reset;
  logic [31:0] Instr;
  logic [4:0]  RS;
  logic [4:0]  RT;
  logic [4:0]  WR;
  logic [4:0]  Instype;
  logic        md_stall;

  int errors = 0;
  int checks = 0;

  at_decoder dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Instr    (Instr),
    .RS       (RS),
    .RT       (RT),
    .WR       (WR),
    .Instype  (Instype),
    .md_stall (md_stall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Compare {Instype,RS,RT,WR,md_stall} against the expected tuple.
  task automatic chk(input string tag, input logic [4:0] e_ty, input logic [4:0] e_rs,
                     input logic [4:0] e_rt, input logic [4:0] e_wr, input logic e_md);
    logic [20:0] obs;
    logic [20:0] exp_v;
    obs   = {Instype, RS, RT, WR, md_stall};
    exp_v = {e_ty, e_rs, e_rt, e_wr, e_md};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got ty=%0d rs=%0d rt=%0d wr=%0d md=%0b, want ty=%0d rs=%0d rt=%0d wr=%0d md=%0b",
             tag, Instype, RS, RT, WR, md_stall, e_ty, e_rs, e_rt, e_wr, e_md);
    end
  endtask

  // Apply an instruction mid-cycle and check the combinational result.
  task automatic step(input string tag, input logic [31:0] ins, input logic [4:0] e_ty,
                      input logic [4:0] e_rs, input logic [4:0] e_rt, input logic [4:0] e_wr,
                      input logic e_md);
    @(negedge Clk);
    Instr = ins;
    #1;
    chk(tag, e_ty, e_rs, e_rt, e_wr, e_md);
  endtask

  initial begin
    Reset = 1'b0;
    Instr = 32'h02324020;
    #2;
    chk("reset_add", 0, 0, 0, 0, 0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    chk("released_not_ready", 0, 0, 0, 0, 0);
    @(posedge Clk);
    #1;
    chk("add_after_edge", 1, 17, 18, 8, 0);

    step("lw",      32'h8E290004, 3, 17, 0, 9, 0);
    step("sw",      32'hAE290004, 4, 17, 9, 0, 0);
    step("jal",     32'h0C000010, 7, 0, 0, 31, 0);
    step("jr",      32'h03E00008, 6, 31, 0, 0, 0);
    step("mult",    32'h02320018, 1, 17, 18, 0, 1);
    step("mfhi",    32'h00004010, 1, 0, 0, 8, 1);
    step("bgezal",  32'h06310008, 11, 17, 0, 31, 0);
    step("lui",     32'h3C080001, 2, 0, 0, 8, 0);
    step("zero",    32'h00000000, 0, 0, 0, 0, 0);
    step("op3f",    32'hFC000000, 0, 0, 0, 0, 0);
    step("beq",     32'h12320000, 5, 17, 18, 0, 0);
    step("blez",    32'h1A200000, 5, 17, 0, 0, 0);
    step("bltz",    32'h06200000, 5, 17, 0, 0, 0);
    step("regimm10",32'h06300000, 0, 0, 0, 0, 0);
    step("lwl",     32'h8A290000, 9, 17, 9, 9, 0);
    step("lwpl",    32'hCE290000, 10, 17, 0, 9, 0);
    step("jalr",    32'h02204009, 8, 17, 0, 8, 0);
    step("bgezalr", 32'h02320005, 12, 17, 18, 31, 0);
    step("mthi",    32'h02200011, 1, 17, 0, 0, 1);
    step("j",       32'h08000010, 0, 0, 0, 0, 0);
    step("srl",     32'h00124082, 1, 0, 18, 8, 0);
    step("sll",     32'h00084080, 1, 0, 8, 8, 0);
    step("spec01",  32'h02324001, 0, 0, 0, 0, 0);
    step("addiu",   32'h26280005, 2, 17, 0, 8, 0);

    // Mid-stream reset: outputs must drop without a clock edge.
    @(negedge Clk);
    Instr = 32'h02324020;
    #1;
    chk("pre_reset_add", 1, 17, 18, 8, 0);
    Reset = 1'b0;
    #1;
    chk("mid_reset", 0, 0, 0, 0, 0);
    #1;
    Reset = 1'b1;
    #1;
    chk("release_wait", 0, 0, 0, 0, 0);
    @(posedge Clk);
    #1;
    chk("ready_again", 1, 17, 18, 8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, got running want done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/at_decoder.md
# at_decoder

Decode-stage instruction classifier for the 5-stage MIPS pipeline. It takes the 32-bit instruction word and produces three things. The first is its register-usage triple: source registers RS/RT and destination WR. The second is a 5-bit instruction-class code. The third is a multiply/divide flag. The hazard unit consumes these to drive stall and forwarding decisions, and pipelines them into its E/M/W copies.

## Interface
- No parameters.
- Clk  in  1  pipeline clock; sole use is the ready register.
- Reset  in  1  asynchronous, active-low reset.
- Instr  in  32  D-stage instruction word.
- RS  out  5  register read in rs role; 0 if not read.
- RT  out  5  register read in rt role; 0 if not read.
- WR  out  5  destination register; 0 if none.
- Instype  out  5  class code.
- md_stall  out  1  instruction uses the multiply/divide unit.

## Operation
- Class codes:
  - nop=0, cal_r=1, cal_i=2, load=3, store=4, branch=5, jr=6, jal=7
  - jalr=8, lwl=9, lwpl=10, bgezal=11, bgezalr=12
  - Codes 13–31 are unused and never driven.
- op=Instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
- Instr==0, or any unlisted encoding: Instype=nop, RS=RT=WR=0, md_stall=0.
- op=0 (SPECIAL):
  - addu 21, subu 23, add 20, sub 22, and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B, sllv 04, srlv 06, srav 07 → cal_r; RS=rs, RT=rt, WR=rd.
  - sll 00, srl 02, sra 03 (nonzero word) → cal_r; RS=0, RT=rt, WR=rd.
  - jr 08 → jr; RS=rs, RT=0, WR=0.
  - jalr 09 → jalr; RS=rs, RT=0, WR=rd.
  - bgezalr 05 → bgezalr; RS=rs, RT=rt, WR=31.
  - mult 18, multu 19, div 1A, divu 1B → cal_r; RS=rs, RT=rt, WR=0, md_stall=1.
  - mthi 11, mtlo 13 → cal_r; RS=rs, RT=0, WR=0, md_stall=1.
  - mfhi 10, mflo 12 → cal_r; RS=RT=0, WR=rd, md_stall=1.
- op=01 (REGIMM):
  - rt=00 bltz, 01 bgez → branch; RS=rs, RT=0, WR=0.
  - rt=11 bgezal → bgezal; RS=rs, RT=0, WR=31.
- Branches:
  - beq 04, bne 05 → branch; RS=rs, RT=rt, WR=0.
  - blez 06, bgtz 07 → branch; RS=rs, RT=0, WR=0.
- Jumps: j 02 → nop with all register fields 0; jal 03 → jal; WR=31.
- Immediate arithmetic: addi 08, addiu 09, slti 0A, sltiu 0B, andi 0C, ori 0D, xori 0E → cal_i; RS=rs, RT=0, WR=rt. lui 0F → cal_i; RS=0, RT=0, WR=rt.
- Memory:
  - lb 20, lh 21, lw 23, lbu 24, lhu 25 → load; RS=rs, RT=0, WR=rt.
  - sb 28, sh 29, sw 2B → store; RS=rs, RT=rt, WR=0.
  - lwl 22 → lwl; RS=rs, RT=rt, WR=rt.
  - lwpl 33 → lwpl; RS=rs, RT=0, WR=rt. The hazard unit separately treats $31 as a possible destination.
- md_stall=0 for every instruction not listed above as md.

## Timing
- Decode is purely combinational: zero latency, and outputs follow Instr within the same cycle.
- Internal 1-bit `ready` register:
  - Cleared asynchronously while Reset=0.
  - Set on the first Clk rising edge with Reset=1, then stays set.
- While ready=0, outputs are forced to nop/0/0/0/0 regardless of Instr. Reset asserted mid-operation forces this immediately, without waiting for a clock edge.
- Reset values: RS=RT=WR=0, Instype=0, md_stall=0.

## Test plan
- Reset low with Instr=0x02324020 (add $8,$17,$18) → all outputs 0; release Reset, clock once → Instype=1, RS=17, RT=18, WR=8, md_stall=0.
- Instr=0x8E290004 (lw $9,4($17)) → Instype=3, RS=17, RT=0, WR=9; Instr=0xAE290004 (sw) → Instype=4, RS=17, RT=9, WR=0.
- Instr=0x0C000010 (jal) → Instype=7, WR=31, RS=RT=0; Instr=0x03E00008 (jr $31) → Instype=6, RS=31, WR=0.
- Instr=0x02320018 (mult $17,$18) → Instype=1, RS=17, RT=18, WR=0, md_stall=1; Instr=0x00004010 (mfhi $8) → WR=8, RS=RT=0, md_stall=1.
- Instr=0x06310008 (bgezal $17) → Instype=11, RS=17, WR=31; Instr=0x3C080001 (lui $8) → Instype=2, RS=0, WR=8.
- Instr=0x00000000 and Instr=0xFC000000 → Instype=0, all fields 0; assert Reset low mid-stream → outputs drop to 0 in the same cycle.
